// File: rtl/aes_pkg.sv
// Shared AES decryption-datapath types, constants and the inverse S-box lookup.
package aes_pkg;

    localparam int unsigned AES_NB      = 4;
    localparam int unsigned AES_WORD_W  = 32;
    localparam int unsigned AES_STATE_W = 128;

    typedef logic [AES_STATE_W-1:0] aes_state_t;
    typedef logic [AES_WORD_W-1:0]  aes_word_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } fsm_state_t;

    // FIPS-197 inverse S-box; entry 0 occupies the most significant byte.
    localparam logic [2047:0] INV_SBOX_TABLE = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    // Entry k sits at bit offset 8*(255-k), i.e. {~k, 3'b000}.
    function automatic logic [7:0] inv_sbox_byte(input logic [7:0] b);
        return INV_SBOX_TABLE[{~b, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/inv_sbox.sv
// Combinational inverse S-box for one 32-bit column (four independent byte lookups).
module inv_sbox
    import aes_pkg::*;
(
    input  logic [AES_WORD_W-1:0] din,
    output logic [AES_WORD_W-1:0] dout_c
);

    // Bytewise table lookup; no arithmetic between bytes.
    always_comb begin
        dout_c = '0;
        for (int b = 0; b < 4; b++) begin
            dout_c[8*b +: 8] = inv_sbox_byte(din[8*b +: 8]);
        end
    end

endmodule

// File: rtl/inv_sub_bytes_iter.sv
// Iterative InvSubBytes: substitutes LANES columns per cycle of a registered 128-bit state.
module inv_sub_bytes_iter
    import aes_pkg::*;
#(
    parameter int unsigned LANES = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_STATE_W-1:0] in_state,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_STATE_W-1:0] out_state,
    output logic                   busy
);

    localparam int unsigned       COL_W    = 2;
    localparam logic [COL_W-1:0]  COL_STEP = COL_W'(LANES);
    localparam logic [COL_W-1:0]  LAST_COL = COL_W'(AES_NB - LANES);

    fsm_state_t       state_q, state_d;
    logic [COL_W-1:0] col_q, col_d;
    aes_state_t       data_q, data_d;
    logic             in_ready_q, out_valid_q, busy_q;

    logic [COL_W-1:0] lane_col [LANES];
    aes_word_t        lane_in  [LANES];
    aes_word_t        lane_out [LANES];

    // One inverse S-box word unit per lane, fed from the column group at col_q.
    for (genvar g = 0; g < int'(LANES); g++) begin : g_lane
        assign lane_col[g] = col_q + COL_W'(g);
        assign lane_in[g]  = data_q[{~lane_col[g], 5'b00000} +: AES_WORD_W];

        inv_sbox u_inv_sbox (
            .din    (lane_in[g]),
            .dout_c (lane_out[g])
        );
    end

    // Next-state logic: accept in IDLE, substitute in place in BUSY, hold in DONE.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    data_d  = in_state;
                    col_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                for (int i = 0; i < int'(LANES); i++) begin
                    data_d[{~lane_col[i], 5'b00000} +: AES_WORD_W] = lane_out[i];
                end
                col_d = col_q + COL_STEP;
                if (col_q == LAST_COL) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; handshake flags are registered from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            col_q       <= '0;
            data_q      <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            data_q      <= data_d;
            in_ready_q  <= (state_d == IDLE);
            out_valid_q <= (state_d == DONE);
            busy_q      <= (state_d != IDLE);
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_state = data_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_inv_sub_bytes_iter.sv
// Bench for inv_sub_bytes_iter with LANES = 1, 2, 4 side by side.
module tb_inv_sub_bytes_iter;

    localparam int unsigned NINST = 3;

    // Forward AES S-box, used to build inputs whose inverse is known.
    localparam logic [2047:0] FWD_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid  [NINST];
    logic         in_ready  [NINST];
    logic [127:0] in_state;
    logic         out_valid [NINST];
    logic         out_ready [NINST];
    logic [127:0] out_state [NINST];
    logic         busy      [NINST];

    int n_assert = 0;
    int n_fail   = 0;
    logic [127:0] sb_q [$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < int'(NINST); g++) begin : g_dut
        inv_sub_bytes_iter #(.LANES(1 << g)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .in_state  (in_state),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .out_state (out_state[g]),
            .busy      (busy[g])
        );
    end

    function automatic logic [7:0] fwd_byte(input logic [7:0] b);
        int hi;
        hi = 2047 - 8 * int'(b);
        return FWD_TABLE[hi -: 8];
    endfunction

    function automatic logic [127:0] fwd_state(input logic [127:0] s);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = fwd_byte(s[8*i +: 8]);
        return r;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Complete the output transfer and confirm the engine is back in IDLE.
    task automatic do_release(input int idx);
        out_ready[idx] = 1'b1;
        @(posedge clk); #1;
        out_ready[idx] = 1'b0;
        check("post_xfer_out_valid", 128'(out_valid[idx]), 128'd0);
        check("post_xfer_busy", 128'(busy[idx]), 128'd0);
        check("post_xfer_in_ready", 128'(in_ready[idx]), 128'd1);
    endtask

    // Drive one state, check latency and result against the scoreboard. Called at #1 after an edge.
    task automatic run_one(input int idx, input logic [127:0] din, input logic [127:0] expv,
                           input bit release_now);
        int guard;
        int lat;
        logic [127:0] want;
        sb_q.push_back(expv);
        in_state      = din;
        in_valid[idx] = 1'b1;
        guard = 0;
        while (in_ready[idx] !== 1'b1 && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        check("accept_wait", 128'(guard < 20), 128'd1);
        @(posedge clk); #1;
        in_valid[idx]  = 1'b0;
        in_state       = {$urandom, $urandom, $urandom, $urandom};
        out_ready[idx] = 1'bx;
        lat = 0;
        while (out_valid[idx] !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        out_ready[idx] = 1'b0;
        check("latency", 128'(lat), 128'(4 >> idx));
        if (sb_q.size() == 0) begin
            check("scoreboard_empty", 128'd1, 128'd0);
        end else begin
            want = sb_q.pop_front();
            check("data", out_state[idx], want);
        end
        if (release_now) do_release(idx);
    endtask

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [127:0] orig;
        logic [127:0] bp_exp;

        rst = 1'b1;
        in_state = '0;
        for (int i = 0; i < int'(NINST); i++) begin
            in_valid[i]  = 1'b0;
            out_ready[i] = 1'b0;
        end

        // Reset / idle
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < int'(NINST); i++) begin
            check("rst_out_valid", 128'(out_valid[i]), 128'd0);
            check("rst_out_state", out_state[i], 128'd0);
            check("rst_busy", 128'(busy[i]), 128'd0);
            check("rst_in_ready", 128'(in_ready[i]), 128'd0);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < int'(NINST); i++) begin
            check("idle_in_ready", 128'(in_ready[i]), 128'd1);
            check("idle_busy", 128'(busy[i]), 128'd0);
        end

        // Directed values on LANES=1
        run_one(0, {16{8'h63}}, 128'd0, 1'b1);
        run_one(0, {4{32'h7c777bf2}}, {4{32'h01020304}}, 1'b1);
        run_one(0, 128'd0, {16{8'h52}}, 1'b1);
        run_one(0, {8'h16, 120'd0}, {8'hff, {15{8'h52}}}, 1'b1);

        // Backpressure: result held, in_valid pulses ignored
        bp_exp = {32'h01020304, 32'h52525252, 32'h00000000, 32'hff525252};
        run_one(0, {32'h7c777bf2, 32'h00000000, 32'h63636363, 32'h16000000}, bp_exp, 1'b0);
        for (int k = 0; k < 10; k++) begin
            in_valid[0] = (k % 3 == 0);
            in_state    = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk); #1;
            check("bp_out_state", out_state[0], bp_exp);
            check("bp_out_valid", 128'(out_valid[0]), 128'd1);
            check("bp_in_ready", 128'(in_ready[0]), 128'd0);
        end
        in_valid[0] = 1'b0;
        do_release(0);
        @(posedge clk); #1;
        check("bp_no_stray_accept", 128'(busy[0]), 128'd0);

        // Mid-operation reset at col=2
        in_state    = {16{8'h63}};
        in_valid[0] = 1'b1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("pre_abort_busy", 128'(busy[0]), 128'd1);
        #2 rst = 1'b1;
        #1;
        check("abort_out_valid", 128'(out_valid[0]), 128'd0);
        check("abort_busy", 128'(busy[0]), 128'd0);
        check("abort_out_state", out_state[0], 128'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            check("abort_no_valid", 128'(out_valid[0]), 128'd0);
        end
        run_one(0, {4{32'h7c777bf2}}, {4{32'h01020304}}, 1'b1);

        // Round trip through forward S-box, all byte values first, then random
        for (int idx = 0; idx < int'(NINST); idx++) begin
            for (int n = 0; n < 1000; n++) begin
                if (n < 16) begin
                    for (int b = 0; b < 16; b++) orig[8*b +: 8] = 8'(16 * n + b);
                end else begin
                    orig = {$urandom, $urandom, $urandom, $urandom};
                end
                run_one(idx, fwd_state(orig), orig, 1'b1);
            end
        end

        check("scoreboard_drained", 128'(sb_q.size()), 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
